sample_capture_arbiter: RTL and testbench
=========================================

Name: sample_capture_arbiter

Overview:
- Shares the single push port of the bus-sample FIFO among four capture sources: write address, write data, read address and read data.
- Each source gets a one-entry holding register, so coincident events are serialised in round-robin order instead of being resolved by fixed priority or lost.
- Adds run control: enable, one-shot sample limit, clear, and drop/sample counters.
- Sits in the monitored clock domain, between the per-source sample qualifiers and the write side of the sample FIFO.

Parameters:
- DW, 32, sample data width.
- CW, 8, width of the sample-limit, sample-count and drop-count fields.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  capture run enable (level).
- clr  input  1  single-cycle pulse; clears counters, holding registers and DONE.
- limit  input  CW  one-shot sample limit; 0 = free-running.
- req  input  4  capture strobes. Bit 3 = waddr, bit 2 = wdata, bit 1 = raddr, bit 0 = rdata.
- req_data  input  4*DW  sample words; source i occupies bits [i*DW +: DW].
- fifo_full  input  1  sample FIFO full.
- fifo_push  output  1  push strobe to the sample FIFO.
- fifo_wdata  output  DW  word pushed.
- fifo_src  output  2  index of the source being pushed (for tagging).
- sample_cnt  output  CW  pushes since clear; saturating.
- drop_cnt  output  CW  requests lost to an occupied holding register; saturating.
- done  output  1  limit reached.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, hv[3:0]=0, hd=0, rr=0, sample_cnt=0, drop_cnt=0.
  - Outputs: fifo_push=0, fifo_wdata=0, fifo_src=0, done=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0. All hv are cleared on that edge; held samples are discarded and not counted as drops.
  - RUN -> DONE on the edge where a push makes sample_cnt+1 == limit, with limit != 0. hv are cleared on that edge.
  - DONE holds until clr=1 or rst=1; clr moves DONE -> IDLE.
- Capture: applies only in RUN, and only if that edge does not leave RUN.
  - If req[i]=1 and (hv[i]=0 or slot i is granted this cycle): hv[i]<=1, hd[i]<=req_data slice i.
  - Otherwise, if req[i]=1 and hv[i]=1 and slot i is not granted: the request is dropped and drop_cnt increments by 1. Increments are per dropping source and summed, so up to +4 per cycle, saturating at all-ones.
- Grant (combinational from registers):
  - Asserted when state==RUN, |hv=1 and fifo_full=0.
  - Selects the first hv[j] set, searching j = rr, rr+1, ... modulo 4.
- Push outputs:
  - fifo_push = grant valid.
  - fifo_wdata = hd[j]; fifo_src = j.
  - When fifo_push=0: fifo_wdata=0 and fifo_src=0.
- On each push:
  - hv[j]<=0 unless it is reloaded in the same cycle.
  - rr<=(j+1) mod 4.
  - sample_cnt increments, saturating at all-ones.
- Latency: req at edge t becomes visible as fifo_push in cycle t+1 at the earliest.
- Throughput: one push per cycle maximum.
- fifo_full=1 stalls pushes. hv contents hold; new requests to occupied slots count as drops.
- clr=1 (with rst=0), regardless of state:
  - sample_cnt=0, drop_cnt=0, hv=0, rr=0, state=IDLE.
  - clr takes priority over capture, push and limit on the same edge.
- limit changed while in RUN: takes effect on the next compare. If sample_cnt is already >= a new nonzero limit, the next push causes RUN -> DONE.
- done = (state==DONE).

Test Plan:
- Single source: limit=0, enable=1; req=4'b0001 once with data 0xA5A5_0001 -> next cycle fifo_push=1, fifo_wdata=0xA5A5_0001, fifo_src=0; sample_cnt=1; drop_cnt=0.
- Coincident requests: req=4'b1111 in one cycle, rr=0 -> pushes on 4 consecutive cycles with fifo_src 0,1,2,3; sample_cnt=4; drop_cnt=0.
- Backpressure: fifo_full=1 held for 5 cycles while req[3] pulses 3 times -> first captured, other two dropped, drop_cnt=2. Release fifo_full -> exactly one push with the first word.
- Reload on grant: hv[2]=1 is granted in the same cycle req[2]=1 with new data -> that cycle pushes the old word, next cycle pushes the new word; drop_cnt unchanged.
- One-shot: limit=3 with continuous req[1] -> exactly 3 pushes, done=1, no further pushes. clr pulse -> done=0, sample_cnt=0, state IDLE (RUN next cycle with enable=1).
- Sync reset mid-run: rst=1 for one edge with hv=4'b0110 and fifo_full=0 -> next cycle fifo_push=0, sample_cnt=0, done=0. With rst=0 and enable=1, capture resumes the following edge.

Source files
------------

// File: rtl/sample_capture_arbiter.sv
// Round-robin arbiter that serialises four bus-sample sources onto one FIFO push port,
// with one-entry holding registers, run control and saturating sample/drop counters.
module sample_capture_arbiter #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            clr,
  input  logic [CW-1:0]   limit,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] req_data,
  input  logic            fifo_full,
  output logic            fifo_push,
  output logic [DW-1:0]   fifo_wdata,
  output logic [1:0]      fifo_src,
  output logic [CW-1:0]   sample_cnt,
  output logic [CW-1:0]   drop_cnt,
  output logic            done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_hv;
  logic [DW-1:0] r_hd [4];
  logic [1:0]    r_rr;
  logic [CW-1:0] r_sample_cnt;
  logic [CW-1:0] r_drop_cnt;

  logic [7:0]    w_hv_dbl;
  logic [3:0]    w_hv_rot;
  logic [1:0]    w_off;
  logic [1:0]    w_grant_idx;
  logic          w_push;
  logic [CW:0]   w_cnt_inc;
  logic          w_limit_hit;
  logic          w_capture_en;
  logic [3:0]    w_granted;
  logic [3:0]    w_load;
  logic [3:0]    w_drop;
  logic [2:0]    w_drop_num;
  logic [CW:0]   w_drop_sum;
  logic [3:0]    w_hv_next;

  // Rotate hv so bit 0 is the slot at the round-robin pointer, then take the lowest set bit.
  always_comb begin
    w_hv_dbl = {r_hv, r_hv} >> r_rr;
    w_hv_rot = w_hv_dbl[3:0];
    if (w_hv_rot[0])      w_off = 2'd0;
    else if (w_hv_rot[1]) w_off = 2'd1;
    else if (w_hv_rot[2]) w_off = 2'd2;
    else                  w_off = 2'd3;
    w_grant_idx = r_rr + w_off;
  end

  assign w_push     = (r_state == S_RUN) && (|r_hv) && !fifo_full;
  assign fifo_push  = w_push;
  assign fifo_wdata = w_push ? r_hd[w_grant_idx] : '0;
  assign fifo_src   = w_push ? w_grant_idx : 2'd0;

  // ">=" rather than "==" so a limit lowered below the current count still ends the run.
  assign w_cnt_inc    = {1'b0, r_sample_cnt} + 1'b1;
  assign w_limit_hit  = w_push && (limit != '0) && (w_cnt_inc >= {1'b0, limit});
  assign w_capture_en = (r_state == S_RUN) && enable && !w_limit_hit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_granted  = '0;
    w_load     = '0;
    w_drop     = '0;
    w_hv_next  = r_hv;
    w_drop_num = '0;
    for (int i = 0; i < 4; i++) begin
      w_granted[i] = w_push && (w_grant_idx == 2'(i));
      w_load[i]    = w_capture_en && req[i] && (!r_hv[i] || w_granted[i]);
      w_drop[i]    = w_capture_en && req[i] && r_hv[i] && !w_granted[i];
      if (w_load[i])         w_hv_next[i] = 1'b1;
      else if (w_granted[i]) w_hv_next[i] = 1'b0;
      w_drop_num = w_drop_num + {2'b00, w_drop[i]};
    end
    if (!w_capture_en) w_hv_next = '0;
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CW-2){1'b0}}, w_drop_num};

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_hv         <= '0;
      r_rr         <= '0;
      r_sample_cnt <= '0;
      r_drop_cnt   <= '0;
      // NOTE: the holding words are only four registers, so they are reset to keep the bus deterministic.
      for (int i = 0; i < 4; i++) r_hd[i] <= '0;
    end else if (clr) begin
      r_state      <= S_IDLE;
      r_hv         <= '0;
      r_rr         <= '0;
      r_sample_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (enable) r_state <= S_RUN;
        S_RUN: begin
          if (w_limit_hit)  r_state <= S_DONE;
          else if (!enable) r_state <= S_IDLE;
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase

      r_hv <= w_hv_next;
      for (int i = 0; i < 4; i++) begin
        if (w_load[i]) r_hd[i] <= req_data[i*DW +: DW];
      end

      if (w_push) begin
        r_rr <= w_grant_idx + 2'd1;
        if (r_sample_cnt != '1) r_sample_cnt <= w_cnt_inc[CW-1:0];
      end

      r_drop_cnt <= w_drop_sum[CW] ? '1 : w_drop_sum[CW-1:0];
    end
  end

  assign sample_cnt = r_sample_cnt;
  assign drop_cnt   = r_drop_cnt;
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_sample_capture_arbiter.sv
// Directed bench for sample_capture_arbiter: expected pushes are queued by the stimulus
// and popped by a negedge monitor; counters and flags are checked at fixed points.
module tb_sample_capture_arbiter;
  localparam int DW = 32;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            clr;
  logic [CW-1:0]   limit;
  logic [3:0]      req;
  logic [4*DW-1:0] req_data;
  logic            fifo_full;
  logic            fifo_push;
  logic [DW-1:0]   fifo_wdata;
  logic [1:0]      fifo_src;
  logic [CW-1:0]   sample_cnt;
  logic [CW-1:0]   drop_cnt;
  logic            done;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t m_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  sample_capture_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clr        (clr),
    .limit      (limit),
    .req        (req),
    .req_data   (req_data),
    .fifo_full  (fifo_full),
    .fifo_push  (fifo_push),
    .fifo_wdata (fifo_wdata),
    .fifo_src   (fifo_src),
    .sample_cnt (sample_cnt),
    .drop_cnt   (drop_cnt),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input logic [1:0] s, input logic [DW-1:0] d);
    exp_t e;
    e.src  = s;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  // Monitor: every push must match the head of the scoreboard; idle cycles must show a zero bus.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fifo_push === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_push: got src %0d data 0x%0h, expected no push", fifo_src, fifo_wdata);
        end else begin
          m_exp = sb.pop_front();
          check("push_src", 64'(fifo_src), 64'(m_exp.src));
          check("push_data", 64'(fifo_wdata), 64'(m_exp.data));
        end
      end else begin
        check("idle_bus", 64'({fifo_push, fifo_src, fifo_wdata}), 64'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; clr = 1'b0; limit = '0;
    req = '0; req_data = '0; fifo_full = 1'b0;
    tick();
    tick();
    check("rst_push", 64'(fifo_push), 64'd0);
    check("rst_bus", 64'({fifo_src, fifo_wdata}), 64'd0);
    check("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single source
    enable = 1'b1;
    tick();
    req = 4'b0001; set_word(0, 32'hA5A5_0001);
    expect_push(2'd0, 32'hA5A5_0001);
    tick();
    req = '0;
    tick();
    check("t1_sample_cnt", 64'(sample_cnt), 64'd1);
    check("t1_drop_cnt", 64'(drop_cnt), 64'd0);

    // Coincident requests from rr=0
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t2_clr_sample_cnt", 64'(sample_cnt), 64'd0);
    tick();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      set_word(i, 32'hC0DE_0000 + 32'(i));
      expect_push(2'(i), 32'hC0DE_0000 + 32'(i));
    end
    tick();
    req = '0;
    repeat (4) tick();
    check("t2_sample_cnt", 64'(sample_cnt), 64'd4);
    check("t2_drop_cnt", 64'(drop_cnt), 64'd0);

    // Backpressure: three pulses on waddr while full
    fifo_full = 1'b1;
    req = 4'b1000; set_word(3, 32'hBBBB_0001);
    expect_push(2'd3, 32'hBBBB_0001);
    tick();
    req = '0;
    tick();
    req = 4'b1000; set_word(3, 32'hBBBB_0002);
    tick();
    req = '0;
    tick();
    req = 4'b1000; set_word(3, 32'hBBBB_0003);
    tick();
    req = '0;
    check("t3_drop_cnt", 64'(drop_cnt), 64'd2);
    check("t3_stalled_cnt", 64'(sample_cnt), 64'd4);
    fifo_full = 1'b0;
    tick();
    tick();
    check("t3_sample_cnt", 64'(sample_cnt), 64'd5);
    check("t3_sb_drained", 64'(sb.size()), 64'd0);

    // Reload on grant
    req = 4'b0100; set_word(2, 32'h0000_01D0);
    expect_push(2'd2, 32'h0000_01D0);
    tick();
    req = 4'b0100; set_word(2, 32'h0000_0E30);
    expect_push(2'd2, 32'h0000_0E30);
    tick();
    req = '0;
    tick();
    check("t4_sample_cnt", 64'(sample_cnt), 64'd7);
    check("t4_drop_cnt", 64'(drop_cnt), 64'd2);

    // One-shot limit with continuous raddr requests
    clr = 1'b1; limit = 8'd3;
    tick();
    clr = 1'b0;
    tick();
    for (int k = 1; k <= 6; k++) begin
      req = 4'b0010; set_word(1, 32'h1000_0000 + 32'(k));
      if (k <= 3) expect_push(2'd1, 32'h1000_0000 + 32'(k));
      tick();
    end
    req = '0;
    check("t5_done", 64'(done), 64'd1);
    check("t5_sample_cnt", 64'(sample_cnt), 64'd3);
    check("t5_drop_cnt", 64'(drop_cnt), 64'd0);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0; limit = '0;
    check("t5_clr_done", 64'(done), 64'd0);
    check("t5_clr_sample_cnt", 64'(sample_cnt), 64'd0);
    tick();
    req = 4'b0001; set_word(0, 32'h5555_0000);
    expect_push(2'd0, 32'h5555_0000);
    tick();
    req = '0;
    tick();
    check("t5_rerun_cnt", 64'(sample_cnt), 64'd1);

    // Synchronous reset with hv=0110; the rr=1 slot is granted during the reset cycle
    req = 4'b0110; set_word(1, 32'h6666_0001); set_word(2, 32'h6666_0002);
    expect_push(2'd1, 32'h6666_0001);
    tick();
    req = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_push", 64'(fifo_push), 64'd0);
    check("t6_sample_cnt", 64'(sample_cnt), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    tick();
    req = 4'b1000; set_word(3, 32'h7777_0003);
    expect_push(2'd3, 32'h7777_0003);
    tick();
    req = '0;
    tick();
    check("t6_resume_cnt", 64'(sample_cnt), 64'd1);

    repeat (2) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
